// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between the host link and the inference core.
// Round-robin grants, optional owner lock with watchdog, latency-matched read tags.
//
// owner state | meaning
// OWN_NONE    | no lock held, round-robin between requesters
// OWN_HOST    | host holds the port, core waits
// OWN_CORE    | core holds the port, host waits
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 2,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  host_req_in,
  input  logic                  host_we_in,
  input  logic                  host_lock_in,
  input  logic [ADDR_WIDTH-1:0] host_addr_in,
  input  logic [DATA_WIDTH-1:0] host_wdata_in,
  output logic                  host_gnt_out,
  output logic                  host_rvalid_out,
  input  logic                  core_req_in,
  input  logic                  core_we_in,
  input  logic                  core_lock_in,
  input  logic [ADDR_WIDTH-1:0] core_addr_in,
  input  logic [DATA_WIDTH-1:0] core_wdata_in,
  output logic                  core_gnt_out,
  output logic                  core_rvalid_out,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  bram_en_out,
  output logic                  bram_we_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [DATA_WIDTH-1:0] bram_wdata_out,
  input  logic [DATA_WIDTH-1:0] bram_rdata_in,
  output logic                  lock_error_out
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic ID_HOST = 1'b0;
  localparam logic ID_CORE = 1'b1;

  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_CORE} owner_t;

  owner_t                  owner, owner_eff, owner_next;
  logic                    last_gnt;
  logic [CNT_W-1:0]        wait_cnt, wait_next;
  logic                    blocked_host, blocked_core;
  logic [READ_LATENCY-1:0] tag_v, tag_id;
  logic                    gnt_h, gnt_c, waiting, expire;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      owner        <= OWN_NONE;
      last_gnt     <= ID_CORE;
      wait_cnt     <= '0;
      blocked_host <= 1'b0;
      blocked_core <= 1'b0;
      tag_v        <= '0;
      tag_id       <= '0;
    end else begin
      owner    <= owner_next;
      wait_cnt <= wait_next;
      if (gnt_h || gnt_c)
        last_gnt <= gnt_c;
      if (expire && owner_eff == OWN_HOST)
        blocked_host <= 1'b1;
      else if (!host_lock_in)
        blocked_host <= 1'b0;
      if (expire && owner_eff == OWN_CORE)
        blocked_core <= 1'b1;
      else if (!core_lock_in)
        blocked_core <= 1'b0;
      tag_v[0]  <= (gnt_h && !host_we_in) || (gnt_c && !core_we_in);
      tag_id[0] <= gnt_c;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    owner_eff  = owner;
    owner_next = OWN_NONE;
    gnt_h      = 1'b0;
    gnt_c      = 1'b0;
    wait_next  = '0;

    // Dropping the lock frees the port in the same cycle.
    if ((owner == OWN_HOST && !host_lock_in) || (owner == OWN_CORE && !core_lock_in))
      owner_eff = OWN_NONE;

    waiting = (owner_eff == OWN_HOST && core_req_in) || (owner_eff == OWN_CORE && host_req_in);
    expire  = waiting && (wait_cnt == CNT_W'(LOCK_TIMEOUT - 1));

    if (!rst_in) begin
      case (owner_eff)
        OWN_HOST: gnt_h = host_req_in;
        OWN_CORE: gnt_c = core_req_in;
        default: begin
          if (host_req_in && core_req_in) begin
            gnt_h = (last_gnt == ID_CORE);
            gnt_c = (last_gnt == ID_HOST);
          end else begin
            gnt_h = host_req_in;
            gnt_c = core_req_in;
          end
        end
      endcase
    end

    if (waiting && !expire)
      wait_next = wait_cnt + CNT_W'(1);

    if (expire)
      owner_next = OWN_NONE;
    else if (owner_eff != OWN_NONE)
      owner_next = owner_eff;
    else if (gnt_h && host_lock_in && !blocked_host)
      owner_next = OWN_HOST;
    else if (gnt_c && core_lock_in && !blocked_core)
      owner_next = OWN_CORE;
  end

  assign host_gnt_out    = gnt_h;
  assign core_gnt_out    = gnt_c;
  assign lock_error_out  = expire && !rst_in;
  assign bram_en_out     = gnt_h || gnt_c;
  assign bram_we_out     = gnt_h ? host_we_in : (gnt_c && core_we_in);
  assign bram_addr_out   = gnt_h ? host_addr_in : core_addr_in;
  assign bram_wdata_out  = gnt_h ? host_wdata_in : core_wdata_in;
  assign host_rvalid_out = tag_v[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == ID_HOST);
  assign core_rvalid_out = tag_v[READ_LATENCY-1] && (tag_id[READ_LATENCY-1] == ID_CORE);
  assign rdata_out       = bram_rdata_in;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: main instance with default timeout,
// second instance with an 8-cycle lock timeout for the watchdog scenarios.
module tb_bram_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam logic [DW-1:0] VD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [DW-1:0] V1 = 64'h1111_0000_0000_0001;
  localparam logic [DW-1:0] V2 = 64'h2222_0000_0000_0002;
  localparam logic [DW-1:0] V3 = 64'h3333_0000_0000_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic host_req, host_we, host_lock, core_req, core_we, core_lock;
  logic [AW-1:0] host_addr, core_addr;
  logic [DW-1:0] host_wdata, core_wdata;
  logic h_gnt, h_rv, c_gnt, c_rv, bram_en, bram_we, lock_err;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata, rdata, bram_rdata;
  logic w_h_gnt, w_h_rv, w_c_gnt, w_c_rv, w_en, w_we, w_lock_err;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata, w_rdata;

  int n_checks = 0;
  int n_fail = 0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .LOCK_TIMEOUT(4096)) dut (
    .clk_in(clk), .rst_in(rst),
    .host_req_in(host_req), .host_we_in(host_we), .host_lock_in(host_lock),
    .host_addr_in(host_addr), .host_wdata_in(host_wdata),
    .host_gnt_out(h_gnt), .host_rvalid_out(h_rv),
    .core_req_in(core_req), .core_we_in(core_we), .core_lock_in(core_lock),
    .core_addr_in(core_addr), .core_wdata_in(core_wdata),
    .core_gnt_out(c_gnt), .core_rvalid_out(c_rv),
    .rdata_out(rdata), .bram_en_out(bram_en), .bram_we_out(bram_we),
    .bram_addr_out(bram_addr), .bram_wdata_out(bram_wdata),
    .bram_rdata_in(bram_rdata), .lock_error_out(lock_err)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .LOCK_TIMEOUT(8)) dut_wd (
    .clk_in(clk), .rst_in(rst),
    .host_req_in(host_req), .host_we_in(host_we), .host_lock_in(host_lock),
    .host_addr_in(host_addr), .host_wdata_in(host_wdata),
    .host_gnt_out(w_h_gnt), .host_rvalid_out(w_h_rv),
    .core_req_in(core_req), .core_we_in(core_we), .core_lock_in(core_lock),
    .core_addr_in(core_addr), .core_wdata_in(core_wdata),
    .core_gnt_out(w_c_gnt), .core_rvalid_out(w_c_rv),
    .rdata_out(w_rdata), .bram_en_out(w_en), .bram_we_out(w_we),
    .bram_addr_out(w_addr), .bram_wdata_out(w_wdata),
    .bram_rdata_in(bram_rdata), .lock_error_out(w_lock_err)
  );

  // Two-cycle BRAM model driven by the main instance, preloaded while in reset.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_p0, rd_p1;
  always @(posedge clk) begin
    if (rst) begin
      mem[1]  <= V1;
      mem[2]  <= V2;
      mem[3]  <= V3;
      mem[16] <= VD;
    end else if (bram_en && bram_we) begin
      mem[bram_addr[7:0]] <= bram_wdata;
    end
    if (bram_en) rd_p0 <= mem[bram_addr[7:0]];
    rd_p1 <= rd_p0;
  end
  assign bram_rdata = rd_p1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_req = 0; host_we = 0; host_lock = 0; host_addr = '0; host_wdata = '0;
    core_req = 0; core_we = 0; core_lock = 0; core_addr = '0; core_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    host_req = 1; core_req = 1; host_lock = 1; core_we = 1;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, bram_en, bram_we, h_rv, c_rv, lock_err, w_h_gnt, w_c_gnt, w_lock_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: gnt/en/we/rv/err=%b required all 0",
               {h_gnt, c_gnt, bram_en, bram_we, h_rv, c_rv, lock_err, w_h_gnt, w_c_gnt, w_lock_err});
    end
    cyc();
  endtask

  task automatic test_single_read();
    do_reset();
    core_req = 1; core_addr = 14'h0010;
    #2;
    n_checks++;
    if ({c_gnt, h_gnt, bram_en, bram_we} !== 4'b1010) begin
      n_fail++; $display("FAIL single_grant: cgnt/hgnt/en/we=%b required 1010", {c_gnt, h_gnt, bram_en, bram_we});
    end
    n_checks++;
    if (bram_addr !== 14'h0010) begin
      n_fail++; $display("FAIL single_addr: addr=%h required 0010", bram_addr);
    end
    cyc();
    core_req = 0;
    #2;
    n_checks++;
    if ({c_rv, h_rv} !== 2'b00) begin
      n_fail++; $display("FAIL single_early_rvalid: c_rv/h_rv=%b required 00", {c_rv, h_rv});
    end
    cyc();
    #2;
    n_checks++;
    if ({c_rv, h_rv} !== 2'b10) begin
      n_fail++; $display("FAIL single_rvalid: c_rv/h_rv=%b required 10", {c_rv, h_rv});
    end
    n_checks++;
    if (rdata !== VD) begin
      n_fail++; $display("FAIL single_rdata: rdata=%h required %h", rdata, VD);
    end
    cyc();
    #2;
    n_checks++;
    if (c_rv !== 1'b0) begin
      n_fail++; $display("FAIL single_late_rvalid: c_rv=%b required 0", c_rv);
    end
    cyc();
  endtask

  task automatic test_round_robin();
    logic exp_h;
    do_reset();
    host_req = 1; core_req = 1; host_addr = 14'd1; core_addr = 14'd2;
    for (int i = 0; i < 6; i++) begin
      exp_h = (i % 2 == 0);
      #2;
      n_checks++;
      if ({h_gnt, c_gnt, bram_en} !== {exp_h, ~exp_h, 1'b1}) begin
        n_fail++;
        $display("FAIL rr_cycle%0d: hgnt/cgnt/en=%b required %b", i, {h_gnt, c_gnt, bram_en}, {exp_h, ~exp_h, 1'b1});
      end
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();
  endtask

  task automatic test_lock_burst();
    int k;
    logic gap;
    do_reset();
    core_req = 1; core_addr = 14'h0020;
    host_lock = 1; host_we = 1;
    k = 0;
    for (int i = 0; i < 19; i++) begin
      gap = (i == 5 || i == 10 || i == 15);
      host_req = !gap;
      host_addr = 14'h0040 + 14'(k);
      host_wdata = 64'(k);
      #2;
      n_checks++;
      if ({h_gnt, c_gnt} !== {~gap, 1'b0}) begin
        n_fail++; $display("FAIL burst_cycle%0d: hgnt/cgnt=%b required %b", i, {h_gnt, c_gnt}, {~gap, 1'b0});
      end
      if (!gap) begin
        n_checks++;
        if ({bram_we, bram_addr} !== {1'b1, 14'h0040 + 14'(k)}) begin
          n_fail++; $display("FAIL burst_write%0d: we/addr=%b/%h required 1/%h", k, bram_we, bram_addr, 14'h0040 + 14'(k));
        end
        k++;
      end
      cyc();
    end
    host_lock = 0; host_req = 0; host_we = 0;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL burst_release: hgnt/cgnt=%b required 01", {h_gnt, c_gnt});
    end
    cyc();
    idle_inputs();
    repeat (3) cyc();
  endtask

  task automatic test_watchdog();
    do_reset();
    host_req = 1; host_lock = 1; host_addr = 14'd5;
    #2;
    n_checks++;
    if (w_h_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wd_acquire: w_hgnt=%b required 1", w_h_gnt);
    end
    cyc();
    host_req = 0; core_req = 1; core_addr = 14'h0030;
    for (int w = 1; w <= 8; w++) begin
      #2;
      n_checks++;
      if ({w_c_gnt, w_lock_err} !== {1'b0, w == 8}) begin
        n_fail++; $display("FAIL wd_wait%0d: cgnt/err=%b required %b", w, {w_c_gnt, w_lock_err}, {1'b0, w == 8});
      end
      cyc();
    end
    #2;
    n_checks++;
    if ({w_c_gnt, w_lock_err} !== 2'b10) begin
      n_fail++; $display("FAIL wd_after_break: cgnt/err=%b required 10", {w_c_gnt, w_lock_err});
    end
    cyc();
    host_req = 1;
    #2;
    n_checks++;
    if ({w_h_gnt, w_c_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL wd_blocked_rr_host: hgnt/cgnt=%b required 10", {w_h_gnt, w_c_gnt});
    end
    cyc();
    #2;
    n_checks++;
    if ({w_h_gnt, w_c_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL wd_blocked_no_lock: hgnt/cgnt=%b required 01", {w_h_gnt, w_c_gnt});
    end
    cyc();
    host_lock = 0; host_req = 0; core_req = 0;
    cyc();
    host_req = 1; host_lock = 1;
    #2;
    n_checks++;
    if (w_h_gnt !== 1'b1) begin
      n_fail++; $display("FAIL wd_reacquire: w_hgnt=%b required 1", w_h_gnt);
    end
    cyc();
    host_req = 0; core_req = 1;
    for (int w = 1; w <= 8; w++) begin
      if (w == 8) host_lock = 0;
      #2;
      n_checks++;
      if ({w_c_gnt, w_lock_err} !== {w == 8, 1'b0}) begin
        n_fail++; $display("FAIL wd_release_wait%0d: cgnt/err=%b required %b", w, {w_c_gnt, w_lock_err}, {w == 8, 1'b0});
      end
      cyc();
    end
    idle_inputs();
    repeat (3) cyc();
  endtask

  task automatic test_interleaved();
    do_reset();
    host_req = 1; host_addr = 14'd1;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv} !== 4'b1000) begin
      n_fail++; $display("FAIL inter_c0: hgnt/cgnt/hrv/crv=%b required 1000", {h_gnt, c_gnt, h_rv, c_rv});
    end
    cyc();
    host_req = 0; core_req = 1; core_addr = 14'd2;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv} !== 4'b0100) begin
      n_fail++; $display("FAIL inter_c1: hgnt/cgnt/hrv/crv=%b required 0100", {h_gnt, c_gnt, h_rv, c_rv});
    end
    cyc();
    core_req = 0; host_req = 1; host_addr = 14'd3;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv} !== 4'b1010 || rdata !== V1) begin
      n_fail++; $display("FAIL inter_c2: hgnt/cgnt/hrv/crv=%b rdata=%h required 1010 %h", {h_gnt, c_gnt, h_rv, c_rv}, rdata, V1);
    end
    cyc();
    host_req = 0;
    #2;
    n_checks++;
    if ({h_rv, c_rv} !== 2'b01 || rdata !== V2) begin
      n_fail++; $display("FAIL inter_c3: hrv/crv=%b rdata=%h required 01 %h", {h_rv, c_rv}, rdata, V2);
    end
    cyc();
    #2;
    n_checks++;
    if ({h_rv, c_rv} !== 2'b10 || rdata !== V3) begin
      n_fail++; $display("FAIL inter_c4: hrv/crv=%b rdata=%h required 10 %h", {h_rv, c_rv}, rdata, V3);
    end
    cyc();
    #2;
    n_checks++;
    if ({h_rv, c_rv} !== 2'b00) begin
      n_fail++; $display("FAIL inter_c5: hrv/crv=%b required 00", {h_rv, c_rv});
    end
    cyc();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    host_req = 1; host_lock = 1; host_addr = 14'd1;
    cyc();
    host_addr = 14'd2;
    cyc();
    rst = 1; host_req = 0;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv, bram_en, lock_err} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_outputs: %b required 000000", {h_gnt, c_gnt, h_rv, c_rv, bram_en, lock_err});
    end
    cyc();
    rst = 0; core_req = 1; core_addr = 14'd2;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv} !== 4'b0100) begin
      n_fail++; $display("FAIL midrst_owner_cleared: hgnt/cgnt/hrv/crv=%b required 0100", {h_gnt, c_gnt, h_rv, c_rv});
    end
    cyc();
    host_lock = 0; host_req = 1;
    #2;
    n_checks++;
    if ({h_gnt, c_gnt, h_rv, c_rv} !== 4'b1000) begin
      n_fail++; $display("FAIL midrst_tie: hgnt/cgnt/hrv/crv=%b required 1000", {h_gnt, c_gnt, h_rv, c_rv});
    end
    cyc();
    idle_inputs();
    repeat (3) cyc();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock_burst();
    test_watchdog();
    test_interleaved();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one BRAM port (data, weight or op memory; one instance per memory) between two requesters: the UART host link (comms) and the inference core.
- Round-robin arbitration, with an optional lock so comms can hold the port for a multi-piece burst.
- Routes read data back with a latency-matched tag pipeline.
- A lock watchdog breaks a stuck lock so the core cannot be starved.

Parameters:
- ADDR_WIDTH, 14: BRAM address width.
- DATA_WIDTH, 64: BRAM word width.
- READ_LATENCY, 2: cycles from an issued read to valid bram_rdata_in. Range 1..4.
- LOCK_TIMEOUT, 4096: maximum cycles a lock may block a waiting requester.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset. Asynchronous, active-high.
- host_req_in  input  1  host access request.
- host_we_in  input  1  host write (1) or read (0).
- host_lock_in  input  1  host requests exclusive ownership.
- host_addr_in  input  ADDR_WIDTH  host address.
- host_wdata_in  input  DATA_WIDTH  host write data.
- host_gnt_out  output  1  host access issued this cycle.
- host_rvalid_out  output  1  host read data valid on rdata_out.
- core_req_in, core_we_in, core_lock_in, core_addr_in, core_wdata_in  input  1/1/1/ADDR_WIDTH/DATA_WIDTH  core equivalents of the host inputs.
- core_gnt_out, core_rvalid_out  output  1/1  core equivalents of the host outputs.
- rdata_out  output  DATA_WIDTH  read data, shared by both requesters. Equals bram_rdata_in.
- bram_en_out  output  1  BRAM port enable.
- bram_we_out  output  1  BRAM write enable.
- bram_addr_out  output  ADDR_WIDTH  BRAM address.
- bram_wdata_out  output  DATA_WIDTH  BRAM write data.
- bram_rdata_in  input  DATA_WIDTH  BRAM read data.
- lock_error_out  output  1  one-cycle pulse when a lock is forcibly broken.

Behaviour:
- Registered state:
  - last_gnt (HOST/CORE). Reset value CORE, so the host wins the first tie.
  - owner (NONE/HOST/CORE). Reset value NONE.
  - wait_cnt.
  - blocked flag per requester.
  - Tag pipeline of READ_LATENCY stages, each holding {valid, id}.
- Reset values: all registers cleared. While rst_in is high, every gnt, rvalid, bram_en, bram_we and lock_error output is 0.
- Grant is combinational in the cycle of the request. At most one grant per cycle.
  - owner != NONE: only the owner may be granted. The other requester waits, even if the owner is idle (bubble cycles are allowed).
  - owner == NONE, only one requester asserting req: that requester is granted.
  - owner == NONE, both asserting req: the requester that is not last_gnt is granted.
- Issued access:
  - bram_en_out = any grant.
  - bram_we/addr/wdata are muxed from the granted requester.
  - With no grant: bram_addr/wdata hold the core inputs and bram_we_out = 0.
- Writes produce no response.
- Granted read: a tag {1, id} enters the pipeline. The matching rvalid pulses exactly READ_LATENCY cycles after the grant. Back-to-back reads from mixed requesters each return in order. rdata_out is valid only while rvalid is high.
- last_gnt updates to the granted id on every grant.
- Lock acquire:
  - A grant with lock_x = 1 sets owner = x on the next edge, provided x is not blocked.
  - A lock asserted without req has no effect until x is next granted.
- Lock release: while owner == x and lock_x == 0, owner is cleared combinationally. Normal arbitration applies in that same cycle, so the other requester can be granted immediately.
- Watchdog:
  - wait_cnt increments each cycle in which owner != NONE and the non-owner has req high. Otherwise it resets to 0.
  - When wait_cnt reaches LOCK_TIMEOUT: owner is cleared, blocked_x is set for the old owner, and lock_error_out pulses for 1 cycle.
  - A blocked requester still receives ordinary round-robin grants but cannot reacquire the lock.
  - blocked_x clears when lock_x is sampled 0.
- Simultaneous events:
  - A lock release and a watchdog expiry in the same cycle: the release takes precedence and lock_error_out stays 0.
  - A grant to x and x's rvalid in the same cycle is legal.
- Reset mid-operation: outstanding read tags are discarded and no rvalid fires after reset. Any lock is cleared.

Test Plan:
- Idle host, core reads addr 0x0010 with BRAM model value 0xDEAD_BEEF_0000_0001 -> core_gnt same cycle; core_rvalid exactly 2 cycles later with rdata_out = that value; host_rvalid stays 0.
- Both requesters assert req continuously from reset -> grants alternate H,C,H,C; one bram_en per cycle; no cycle with both gnts.
- Host locks and issues 16 writes to addrs 0x40..0x4F with 3 idle gaps while core requests -> core_gnt is 0 throughout the burst. Host drops lock -> core granted that same cycle.
- Host holds lock idle while core requests; LOCK_TIMEOUT=8 -> lock_error_out pulses on the 8th waiting cycle; core granted the next cycle; host lock ignored until host_lock_in is seen low.
- Interleaved reads H@1, C@2, H@3 on consecutive cycles -> rvalid sequence host, core, host with matching data, 2 cycles delayed.
- Assert rst_in for 1 cycle with 2 reads in flight -> no rvalid afterwards; owner cleared; the next tie grants host.
